// File: rtl/spi_master_ctrl.sv
// SPI master: full-duplex, MSB-first, one DATA_W-bit word per accepted start, all CPOL/CPHA modes.
// sclk is derived from clk by a CLK_DIV-cycle half-period counter; CS framing pads both ends.
module spi_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] Tx_byte,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              MISO,
    output logic              sclk,
    output logic              MOSI,
    output logic              CS,
    output logic [DATA_W-1:0] Rx_byte,
    output logic              busy,
    output logic              master_done,
    output logic [2:0]        state_dbg
);

    localparam int EDGES = 2 * DATA_W;
    localparam int ECW   = $clog2(EDGES) + 1;
    localparam int DCW   = $clog2(CLK_DIV) + 1;

    localparam logic [DCW-1:0] DIV_LAST    = DCW'(CLK_DIV - 1);
    localparam logic [ECW-1:0] EDGE_LAST   = ECW'(EDGES);
    localparam logic [ECW-1:0] EDGE_PENULT = ECW'(EDGES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        state;
    logic [DCW-1:0]    div_cnt;
    logic [ECW-1:0]    edge_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              cpol_q;
    logic              cpha_q;

    logic div_done;
    logic edge_fire;
    logic leading;

    assign state_dbg = state;
    assign div_done  = (div_cnt == DIV_LAST);
    // edge_cnt counts edges already produced, so the next edge is odd (leading) when it is even
    assign leading   = ~edge_cnt[0];
    assign edge_fire = div_done &&
                       ((state == S_SETUP) || ((state == S_XFER) && (edge_cnt != EDGE_LAST)));

    // Request handshake: start acts as valid and !busy as ready; a word is accepted on the
    // clk edge where start=1 while idle, and nothing is queued while busy is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            edge_cnt    <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            sclk        <= 1'b0;
            MOSI        <= 1'b0;
            CS          <= 1'b1;
            busy        <= 1'b0;
            master_done <= 1'b0;
            Rx_byte     <= '0;
        end else begin
            master_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    sclk <= CPOL;
                    CS   <= 1'b1;
                    busy <= 1'b0;
                    if (start) begin
                        cpol_q   <= CPOL;
                        cpha_q   <= CPHA;
                        rx_sh    <= '0;
                        CS       <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        state    <= S_SETUP;
                        if (!CPHA) begin
                            MOSI  <= Tx_byte[DATA_W-1];
                            tx_sh <= {Tx_byte[DATA_W-2:0], 1'b0};
                        end else begin
                            tx_sh <= Tx_byte;
                        end
                    end
                end

                S_SETUP, S_XFER: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        if (edge_fire) begin
                            sclk     <= ~sclk;
                            edge_cnt <= edge_cnt + ECW'(1);
                            state    <= S_XFER;
                            if (leading == !cpha_q) begin
                                rx_sh <= {rx_sh[DATA_W-2:0], MISO};
                            end else if (cpha_q || (edge_cnt != EDGE_PENULT)) begin
                                MOSI  <= tx_sh[DATA_W-1];
                                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            // final half-period at idle level has elapsed
                            state <= S_HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end

                S_HOLD: begin
                    sclk <= cpol_q;
                    if (div_done) begin
                        div_cnt     <= '0;
                        CS          <= 1'b1;
                        master_done <= 1'b1;
                        Rx_byte     <= rx_sh;
                        state       <= S_GAP;
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end

                S_GAP: begin
                    sclk <= cpol_q;
                    if (div_done) begin
                        div_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a behavioural SPI slave model feeds MISO and captures MOSI,
// a scoreboard queue holds expected results, and a monitor checks every master_done.
module tb_spi_master_ctrl;

    localparam int CLK_DIV = 4;
    localparam int DATA_W  = 8;
    localparam int LAT     = (2 * DATA_W + 2) * CLK_DIV;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [DATA_W-1:0] Tx_byte = '0;
    logic              CPOL = 1'b0;
    logic              CPHA = 1'b0;
    logic              MISO = 1'b0;
    logic              sclk;
    logic              MOSI;
    logic              CS;
    logic [DATA_W-1:0] Rx_byte;
    logic              busy;
    logic              master_done;
    logic [2:0]        state_dbg;

    spi_master_ctrl #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .Tx_byte(Tx_byte), .CPOL(CPOL), .CPHA(CPHA),
        .MISO(MISO), .sclk(sclk), .MOSI(MOSI), .CS(CS), .Rx_byte(Rx_byte), .busy(busy),
        .master_done(master_done), .state_dbg(state_dbg)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(string name, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // scoreboard
    typedef struct {
        logic [DATA_W-1:0] tx;
        logic [DATA_W-1:0] rx;
        logic              cpol;
        int                acc;
    } exp_t;
    exp_t exp_q[$];
    logic [DATA_W-1:0] last_rx = '0;

    // behavioural slave: mode settings of the frame being modelled
    logic [DATA_W-1:0] m_slv = '0;
    logic              m_cpol = 1'b0;
    logic              m_cpha = 1'b0;
    int                edges = 0;
    int                send_idx = 0;
    logic [DATA_W-1:0] mosi_cap = '0;
    logic              prev_cs = 1'b1;
    logic              prev_sclk = 1'b0;
    int                cs_high = 0;
    logic              framed = 1'b0;

    always @(negedge clk) begin : slave_model
        logic lead;
        logic samp;
        if (prev_cs && !CS) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_frame: CS fell with no transfer issued (t=%0t)", $time);
            end
            check("idle_sclk", sclk, m_cpol);
            if (framed) check("cs_high_gap_ok", (cs_high >= CLK_DIV + 1), 1);
            framed   = 1'b1;
            edges    = 0;
            send_idx = 0;
            mosi_cap = '0;
            if (!m_cpha) begin
                MISO     = m_slv[DATA_W-1];
                send_idx = 1;
            end
        end else if (!CS && (sclk != prev_sclk)) begin
            edges++;
            lead = ((edges % 2) == 1);
            samp = m_cpha ? !lead : lead;
            if (samp) begin
                mosi_cap = {mosi_cap[DATA_W-2:0], MOSI};
            end else if (send_idx < DATA_W) begin
                MISO = m_slv[DATA_W-1-send_idx];
                send_idx++;
            end
        end
        if (CS) cs_high++;
        else    cs_high = 0;
        prev_cs   = CS;
        prev_sclk = sclk;
    end

    // monitor
    logic prev_done = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (master_done) begin
            check("done_one_cycle", prev_done, 0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: master_done with empty queue (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("rx_byte", Rx_byte, e.rx);
                check("mosi_stream", mosi_cap, e.tx);
                check("edge_count", edges, 2 * DATA_W);
                check("latency", cyc - e.acc, LAT);
                check("cs_at_done", CS, 1);
                check("sclk_at_done", sclk, e.cpol);
                last_rx = e.rx;
            end
        end
        prev_done = master_done;
    end

    // driver tasks
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: busy=%0b, required 0 within 400 cycles", busy);
        end
    endtask

    task automatic wait_edges(input int n);
        int k = 0;
        @(negedge clk);
        #1;
        while (edges < n && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (edges < n) begin
            vectors++;
            miscompares++;
            $display("FAIL edge_timeout: edges=%0d, required %0d", edges, n);
        end
    endtask

    task automatic xfer(input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] slv,
                        input logic cpol, input logic cpha);
        exp_t e;
        wait_idle();
        check("rx_hold", Rx_byte, last_rx);
        Tx_byte = tx;
        CPOL    = cpol;
        CPHA    = cpha;
        m_slv   = slv;
        m_cpol  = cpol;
        m_cpha  = cpha;
        e.tx    = tx;
        e.rx    = slv;
        e.cpol  = cpol;
        e.acc   = cyc + 1;
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin : stimulus
        exp_t e;
        int c0;
        int n;
        repeat (3) @(negedge clk);
        check("rst_cs", CS, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_busy", busy, 0);
        check("rst_done", master_done, 0);
        check("rst_rx", Rx_byte, 0);
        rst = 1'b0;

        // mode 0 basic word
        xfer(8'hA5, 8'h3C, 1'b0, 1'b0);

        // all four modes
        for (int m = 0; m < 4; m++) begin
            xfer(8'h81, 8'h7E, m[1], m[0]);
        end

        // shadow registers: inputs changed mid-transfer must not matter
        xfer(8'h0F, 8'h55, 1'b0, 1'b0);
        wait_edges(6);
        Tx_byte = 8'hF0;
        CPOL    = 1'b1;

        // start held high across three frames
        wait_idle();
        check("rx_hold", Rx_byte, last_rx);
        Tx_byte = 8'h96;
        CPOL    = 1'b1;
        CPHA    = 1'b1;
        m_slv   = 8'h69;
        m_cpol  = 1'b1;
        m_cpha  = 1'b1;
        c0 = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            e.tx   = 8'h96;
            e.rx   = 8'h69;
            e.cpol = 1'b1;
            e.acc  = c0 + i * (LAT + CLK_DIV + 1);
            exp_q.push_back(e);
        end
        start = 1'b1;
        repeat (2 * (LAT + CLK_DIV + 1) + 10) @(negedge clk);
        start = 1'b0;

        // random transfers with ignored start pulses and input churn while busy
        for (int i = 0; i < 16; i++) begin
            xfer(DATA_W'($urandom), DATA_W'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(5, 60)) @(negedge clk);
                Tx_byte = DATA_W'($urandom);
                CPOL    = 1'($urandom);
                CPHA    = 1'($urandom);
                start   = 1'b1;
                @(negedge clk);
                start   = 1'b0;
            end
        end

        // reset in the middle of a frame
        xfer(8'hC3, 8'h5A, 1'b0, 1'b1);
        wait_edges(5);
        rst = 1'b1;
        #1;
        check("abort_cs", CS, 1);
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 0);
        check("abort_rx", Rx_byte, 0);
        check("abort_done", master_done, 0);
        void'(exp_q.pop_back());
        last_rx = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);

        // recovery after abort
        xfer(8'h3C, 8'hA5, 1'b1, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d transfers outstanding, required 0", exp_q.size());
        end
        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
